// File: rtl/toggle_stream_tx_pkg.sv
// Shared encodings for the toggle-detector link: receiver states, transmitter
// FSM states, default widths and the receiver next-state function.
package toggle_stream_tx_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_PADW  = 8;

    typedef enum logic {
        ST_A = 1'b0,
        ST_B = 1'b1
    } rx_state_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    // A 1 on d flips the receiver between A and B; a 0 leaves it alone.
    function automatic rx_state_e rx_next(input rx_state_e s, input logic d);
        if (d) begin
            return (s == ST_A) ? ST_B : ST_A;
        end
        return s;
    endfunction

endpackage

// File: rtl/toggle_rx_model.sv
// One-bit model of the toggle-detector receiver: state register plus the
// combinational x output (x=1 only when in A and d=1).
module toggle_rx_model
    import toggle_stream_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_d,
    output logic o_state,
    output logic o_x
);

    rx_state_e r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_A;
        end else if (i_en) begin
            r_state <= rx_next(r_state, i_d);
        end
    end

    assign o_state = r_state;
    assign o_x     = (r_state == ST_A) & i_d;

endmodule

// File: rtl/toggle_stream_tx.sv
// Serializes words MSB-first for the toggle-detector receiver, inserting pad
// bits so the receiver's x equals the data bit on every strobed cycle.
module toggle_stream_tx
    import toggle_stream_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned PADW  = DEFAULT_PADW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_d,
    output logic             tx_strobe,
    output logic             busy,
    output logic             model_state,
    output logic [PADW-1:0]  pad_count
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    tx_state_e        r_state;
    tx_state_e        w_next_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bcnt;
    logic             r_tx_d;
    logic             r_strobe;
    logic             r_busy;
    logic [PADW-1:0]  r_pad;

    logic w_d;
    logic w_strobe;
    logic w_pad;
    logic w_shift;
    logic w_load;
    logic w_b;
    logic w_model;
    logic w_model_x;

    // The mirror advances on exactly the bits driven onto the line in SEND,
    // so it always holds the receiver state after consuming the current tx_d.
    toggle_rx_model u_model (
        .clk     (clk),
        .rst     (reset),
        .i_en    (r_state == SEND),
        .i_d     (w_d),
        .o_state (w_model),
        .o_x     (w_model_x)
    );

    assign w_b = r_shreg[WIDTH-1];

    always_comb begin
        w_next_state = r_state;
        w_d          = 1'b0;
        w_strobe     = 1'b0;
        w_pad        = 1'b0;
        w_shift      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if ((w_model == ST_B) && w_b) begin
                    w_d   = 1'b1;
                    w_pad = 1'b1;
                end else begin
                    w_d      = w_b;
                    w_strobe = 1'b1;
                    w_shift  = 1'b1;
                    if (r_bcnt == CW'(1)) begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bcnt   <= '0;
            r_tx_d   <= 1'b0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_pad    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_tx_d   <= w_d;
            r_strobe <= w_strobe;
            // Covers the post-acceptance cycle and the final bit shown after SEND ends.
            r_busy   <= (w_next_state == SEND) || (r_state == SEND);
            r_pad    <= r_pad + PADW'(w_pad);
            if (w_load) begin
                r_shreg <= in_data;
                r_bcnt  <= CW'(WIDTH);
            end else if (w_shift) begin
                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                r_bcnt  <= r_bcnt - CW'(1);
            end
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign tx_d        = r_tx_d;
    assign tx_strobe   = r_strobe;
    assign busy        = r_busy;
    assign model_state = w_model;
    assign pad_count   = r_pad;

endmodule

// File: tb/tb_toggle_stream_tx.sv
// Self-checking bench for toggle_stream_tx: directed scenarios plus random
// words, checked against a bit-level reference and a receiver scoreboard.
module tb_toggle_stream_tx;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          tx_d;
    logic          tx_strobe;
    logic          busy;
    logic          model_state;
    logic [PW-1:0] pad_count;
    logic          rx_state;
    logic          rx_x;

    int checks = 0;
    int failures = 0;

    logic          ref_state = 1'b0;
    logic [PW-1:0] ref_pad = '0;
    logic [15:0]   obs_d;
    logic [15:0]   obs_s;
    int            obs_len;
    logic          sb_q[$];
    logic          sb_e;

    always #5 clk = ~clk;

    toggle_stream_tx #(.WIDTH(W), .PADW(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx_d        (tx_d),
        .tx_strobe   (tx_strobe),
        .busy        (busy),
        .model_state (model_state),
        .pad_count   (pad_count)
    );

    toggle_rx_model u_rx (
        .clk     (clk),
        .rst     (reset),
        .i_en    (1'b1),
        .i_d     (tx_d),
        .o_state (rx_state),
        .o_x     (rx_x)
    );

    // Receiver-side scoreboard: every strobed x must be the next accepted bit.
    always @(negedge clk) begin
        if (!reset && tx_strobe) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow: strobe with no pending bit at %0t", $time);
            end else begin
                sb_e = sb_q.pop_front();
                if (rx_x !== sb_e) begin
                    failures++;
                    $display("FAIL sb_x: rx x=%b expected %b at %0t", rx_x, sb_e, $time);
                end
            end
        end
        if (!reset && in_valid && in_ready) begin
            for (int i = W - 1; i >= 0; i--) sb_q.push_back(in_data[i]);
        end
    end

    always @(posedge reset) sb_q.delete();

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    // Line sequence from the receiver rules: a 1 seen in B needs a pad first.
    function automatic void ref_stream(input logic [W-1:0] w, input logic st_in,
                                       output logic [15:0] d, output logic [15:0] s,
                                       output int len, output int pads, output logic st_out);
        logic st;
        st = st_in;
        d = '0; s = '0; len = 0; pads = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (st && w[i]) begin
                d = {d[14:0], 1'b1}; s = {s[14:0], 1'b0};
                len++; pads++; st = 1'b0;
            end
            d = {d[14:0], w[i]}; s = {s[14:0], 1'b1};
            len++;
            if (!st && w[i]) st = 1'b1;
        end
        st_out = st;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_state = 1'b0; ref_pad = '0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        logic [15:0] ed, es;
        int len, pads, n;
        logic st_out;
        ref_stream(w, ref_state, ed, es, len, pads, st_out);
        @(posedge clk); #1;
        in_data = w; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = W'($urandom);
        @(negedge clk);
        checks++;
        if ({tx_d, tx_strobe, busy, in_ready} !== 4'b0010) begin
            failures++;
            $display("FAIL first_cycle: d/strobe/busy/ready=%b expected 0010", {tx_d, tx_strobe, busy, in_ready});
        end
        obs_d = '0; obs_s = '0; obs_len = 0;
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            in_data = W'($urandom);
            in_valid = (k < len - 1) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            obs_d = {obs_d[14:0], tx_d}; obs_s = {obs_s[14:0], tx_strobe}; obs_len++;
            checks++;
            if (tx_d !== ed[len-1-k] || tx_strobe !== es[len-1-k]) begin
                failures++;
                $display("FAIL stream w=%h k=%0d: d=%b strobe=%b expected d=%b strobe=%b",
                         w, k, tx_d, tx_strobe, ed[len-1-k], es[len-1-k]);
            end
            checks++;
            if (busy !== 1'b1 || in_ready !== ((k == len - 1) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL ctrl w=%h k=%0d: busy=%b ready=%b", w, k, busy, in_ready);
            end
        end
        @(negedge clk);
        checks++;
        if ({tx_d, tx_strobe, busy, in_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL word_end: d/strobe/busy/ready=%b expected 0001", {tx_d, tx_strobe, busy, in_ready});
        end
        ref_pad = ref_pad + PW'(pads);
        ref_state = st_out;
        checks++;
        if (pad_count !== ref_pad || model_state !== ref_state) begin
            failures++;
            $display("FAIL word_stats w=%h: pad_count=%0d model=%b expected %0d %b",
                     w, pad_count, model_state, ref_pad, ref_state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_d, tx_strobe, busy, model_state} !== 4'b0000 || pad_count !== '0) begin
            failures++;
            $display("FAIL reset_values: d/strobe/busy/model=%b pad=%0d expected 0000 0",
                     {tx_d, tx_strobe, busy, model_state}, pad_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_a5();
        do_reset();
        send_word(8'hA5);
        checks++;
        if (obs_len != 11 || obs_d[10:0] !== 11'b10110011011 || obs_s[10:0] !== 11'b11011101101) begin
            failures++;
            $display("FAIL a5_pattern: len=%0d d=%b s=%b expected 11 10110011011 11011101101",
                     obs_len, obs_d[10:0], obs_s[10:0]);
        end
        checks++;
        if (pad_count !== 8'd3 || model_state !== 1'b1) begin
            failures++;
            $display("FAIL a5_stats: pad=%0d model=%b expected 3 1", pad_count, model_state);
        end
    endtask

    task automatic test_zero();
        do_reset();
        send_word(8'h00);
        checks++;
        if (obs_len != 8 || obs_d[7:0] !== 8'h00 || obs_s[7:0] !== 8'hFF || pad_count !== 8'd0 || model_state !== 1'b0) begin
            failures++;
            $display("FAIL zero_word: len=%0d d=%b s=%b pad=%0d model=%b expected 8 0 ff 0 0",
                     obs_len, obs_d[7:0], obs_s[7:0], pad_count, model_state);
        end
    endtask

    task automatic test_ones();
        do_reset();
        send_word(8'hFF);
        checks++;
        if (obs_len != 15 || pad_count !== 8'd7 || model_state !== 1'b1) begin
            failures++;
            $display("FAIL ff_from_a: len=%0d pad=%0d model=%b expected 15 7 1", obs_len, pad_count, model_state);
        end
        send_word(8'hFF);
        checks++;
        if (obs_len != 16 || pad_count !== 8'd15 || model_state !== 1'b1) begin
            failures++;
            $display("FAIL ff_from_b: len=%0d pad=%0d model=%b expected 16 15 1", obs_len, pad_count, model_state);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1, w2;
        logic [15:0] d1, s1, d2, s2;
        int len1, len2, p1, p2;
        logic st1, st2;
        w1 = W'($urandom); w2 = W'($urandom);
        ref_stream(w1, ref_state, d1, s1, len1, p1, st1);
        ref_stream(w2, st1, d2, s2, len2, p2, st2);
        @(posedge clk); #1;
        in_data = w1; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_first: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_data = W'($urandom);
        @(negedge clk);
        for (int k = 0; k < len1; k++) begin
            @(posedge clk); #1;
            in_data = (k == len1 - 1) ? w2 : W'($urandom);
            @(negedge clk);
            checks++;
            if (tx_d !== d1[len1-1-k] || tx_strobe !== s1[len1-1-k] || busy !== 1'b1 ||
                in_ready !== ((k == len1 - 1) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL b2b_word1 k=%0d: d=%b s=%b busy=%b ready=%b expected d=%b s=%b",
                         k, tx_d, tx_strobe, busy, in_ready, d1[len1-1-k], s1[len1-1-k]);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = W'($urandom);
        @(negedge clk);
        checks++;
        if ({tx_d, tx_strobe, busy, in_ready} !== 4'b0010) begin
            failures++;
            $display("FAIL b2b_gap: d/strobe/busy/ready=%b expected 0010", {tx_d, tx_strobe, busy, in_ready});
        end
        for (int k = 0; k < len2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (tx_d !== d2[len2-1-k] || tx_strobe !== s2[len2-1-k] || busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_word2 k=%0d: d=%b s=%b busy=%b expected d=%b s=%b",
                         k, tx_d, tx_strobe, busy, d2[len2-1-k], s2[len2-1-k]);
            end
        end
        @(negedge clk);
        ref_pad = ref_pad + PW'(p1 + p2);
        ref_state = st2;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || pad_count !== ref_pad || model_state !== ref_state) begin
            failures++;
            $display("FAIL b2b_end: busy=%b ready=%b pad=%0d model=%b expected 0 1 %0d %b",
                     busy, in_ready, pad_count, model_state, ref_pad, ref_state);
        end
    endtask

    task automatic test_reset_midword();
        @(posedge clk); #1;
        in_data = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midword_busy: busy=%b expected 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({tx_d, tx_strobe, busy, model_state} !== 4'b0000 || pad_count !== '0) begin
            failures++;
            $display("FAIL midword_reset: d/strobe/busy/model=%b pad=%0d expected 0000 0",
                     {tx_d, tx_strobe, busy, model_state}, pad_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        ref_state = 1'b0; ref_pad = '0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || tx_d !== 1'b0) begin
            failures++;
            $display("FAIL midword_release: ready=%b busy=%b d=%b expected 1 0 0", in_ready, busy, tx_d);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_word(W'($urandom));
        end
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d bits never strobed, expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_zero();
        test_ones();
        test_back_to_back();
        test_reset_midword();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
